// File: rtl/input_conditioner.sv
// input_conditioner: two-flop synchroniser, per-key debounce with press
// pulses, and a jump-request buffer that holds a jump press for a bounded
// number of game ticks until physics acknowledges it.
module input_conditioner #(
  parameter int NUM_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int CNT_W             = 18,
  parameter int JUMP_BUFFER_TICKS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                game_tick,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                jump_ack,
  output logic                move_right,
  output logic                jump,
  output logic                move_left,
  output logic                any_input_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic                any_press_pulse,
  output logic                jump_req
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } buf_state_e;

  localparam logic [CNT_W-1:0] CNT_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       BUF_RELOAD = 4'(JUMP_BUFFER_TICKS);

  logic [NUM_KEYS-1:0]            sync1_q, sync2_q;
  logic [NUM_KEYS-1:0]            stable_q, stable_d;
  logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]            press_q, press_d;
  buf_state_e                     state_q, state_d;
  logic [3:0]                     buf_cnt_q, buf_cnt_d;

  // Debounce: count while the synchronised input disagrees with the stable
  // value; flip on the terminal count and flag a release-to-press flip.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TERM) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        press_d[i]  = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Jump buffer next state. Arming uses the press event that loads
  // press_q, so jump_req rises in the same cycle as press_pulse[1].
  always_comb begin
    state_d   = state_q;
    buf_cnt_d = buf_cnt_q;
    if (press_d[1]) begin
      state_d   = ARMED;
      buf_cnt_d = BUF_RELOAD;
    end else if (state_q == ARMED && jump_ack) begin
      state_d   = IDLE;
      buf_cnt_d = '0;
    end else if (state_q == ARMED && game_tick) begin
      buf_cnt_d = buf_cnt_q - 4'd1;
      if (buf_cnt_q == 4'd1) state_d = IDLE;
    end
  end

  // All state registers; reset means every key released, buffer idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      stable_q  <= '1;
      cnt_q     <= '0;
      press_q   <= '0;
      state_q   <= IDLE;
      buf_cnt_q <= '0;
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      state_q   <= state_d;
      buf_cnt_q <= buf_cnt_d;
    end
  end

  assign move_right      = ~stable_q[0];
  assign jump            = ~stable_q[1];
  assign move_left       = ~stable_q[2];
  assign any_input_level = |(~stable_q);
  assign press_pulse     = press_q;
  assign any_press_pulse = |press_q;
  assign jump_req        = (state_q == ARMED);

endmodule
